// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO
// Snoops core stores for TX/STATUS addresses; status word is returned combinationally.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_0104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_i,
  input  logic [31:0] data_adr_i,
  input  logic [31:0] write_data_i,
  output logic        hit_o,
  output logic [31:0] read_data_o,
  output logic        tx_o,
  output logic        busy_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic is_tx, is_st, fifo_empty, fifo_full;
  logic push_req, push, pop, ovf_evt, bit_end;
  logic unused_wdata;

  assign is_tx      = (data_adr_i == TX_ADDR);
  assign is_st      = (data_adr_i == STATUS_ADDR);
  assign hit_o      = is_tx | is_st;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign push_req   = mem_write_i & is_tx;
  assign push       = push_req & ~fifo_full;
  assign ovf_evt    = push_req & fifo_full;
  assign bit_end    = (baud_q == BAUD_LAST);
  assign unused_wdata = ^write_data_i[31:8];

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BAUD_ONE;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Back-to-back frames: reload straight into START with no idle bit.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    ovf_d    = ovf_q;
    if (ovf_evt)
      ovf_d = 1'b1;
    else if (mem_write_i && is_st && write_data_i[3])
      ovf_d = 1'b0;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= write_data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    read_data_o = '0;
    if (is_st) begin
      read_data_o[0]    = busy_q;
      read_data_o[1]    = fifo_empty;
      read_data_o[2]    = fifo_full;
      read_data_o[3]    = ovf_q;
      read_data_o[15:8] = 8'(count_q);
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
// Frame-position model checked every cycle, plus hand-computed status and bit expectations.
module tb_mmio_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] TXA = 32'h0000_0100;
  localparam logic [31:0] STA = 32'h0000_0104;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write_i = 1'b0;
  logic [31:0] data_adr_i = '0;
  logic [31:0] write_data_i = '0;
  logic        hit_o, tx_o, busy_o;
  logic [31:0] read_data_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .TX_ADDR     (TXA),
    .STATUS_ADDR (STA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_write_i (mem_write_i),
    .data_adr_i  (data_adr_i),
    .write_data_i(write_data_i),
    .hit_o       (hit_o),
    .read_data_o (read_data_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

  // Model: a byte queue plus "which byte is on the wire and how far into its frame".
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int   sz;
    logic frame_end, pop, push, ovf_ev;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_active = 1'b0;
      m_pos = 0;
      return;
    end
    sz        = mq.size();
    frame_end = m_active && (m_pos == 10 * CPB - 1);
    pop       = (sz > 0) && (!m_active || frame_end);
    push      = mem_write_i && (data_adr_i == TXA);
    ovf_ev    = push && (sz == DEPTH);
    if (pop) m_cur = mq.pop_front();
    if (push && !ovf_ev) mq.push_back(write_data_i[7:0]);
    if (ovf_ev) m_ovf = 1'b1;
    else if (mem_write_i && data_adr_i == STA && write_data_i[3]) m_ovf = 1'b0;
    if (pop) begin
      m_active = 1'b1;
      m_pos = 0;
    end else if (m_active) begin
      if (frame_end) m_active = 1'b0;
      else m_pos++;
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    if (data_adr_i != STA) return s;
    s[0]    = m_active;
    s[1]    = (mq.size() == 0);
    s[2]    = (mq.size() == DEPTH);
    s[3]    = m_ovf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("mon_tx",   {31'b0, tx_o},   {31'b0, exp_tx()});
      check("mon_busy", {31'b0, busy_o}, {31'b0, m_active});
      check("mon_hit",  {31'b0, hit_o},  {31'b0, (data_adr_i == TXA) || (data_adr_i == STA)});
      check("mon_rd",   read_data_o,     exp_status());
    end
  end

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write_i  = 1'b1;
    data_adr_i   = a;
    write_data_i = d;
  endtask

  task automatic idle(input logic [31:0] a);
    @(negedge clk);
    mem_write_i  = 1'b0;
    data_adr_i   = a;
    write_data_i = '0;
    #1;
  endtask

  initial begin
    logic [9:0] fr;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    data_adr_i = STA;
    #1;
    check("rst_tx",     {31'b0, tx_o},   32'd1);
    check("rst_busy",   {31'b0, busy_o}, 32'd0);
    check("rst_status", read_data_o,     32'h0000_0002);
    check("rst_hit",    {31'b0, hit_o},  32'd1);

    // Single 0xA5 frame
    st(TXA, 32'h0000_00A5);
    idle(STA);
    check("a5_queued", read_data_o, 32'h0000_0100);
    check("a5_pre_tx", {31'b0, tx_o}, 32'd1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      #1;
      check("a5_bit",  {31'b0, tx_o},   {31'b0, fr[k / CPB]});
      check("a5_busy", {31'b0, busy_o}, 32'd1);
    end
    @(negedge clk);
    #1;
    check("a5_end_busy", {31'b0, busy_o}, 32'd0);
    check("a5_end_tx",   {31'b0, tx_o},   32'd1);

    // Three back-to-back bytes
    st(TXA, 32'h0000_0041);
    st(TXA, 32'h0000_0042);
    st(TXA, 32'h0000_0043);
    idle(STA);
    check("b2b_count2", read_data_o, 32'h0000_0201);
    repeat (78) @(negedge clk);
    #1;
    check("b2b_count1", read_data_o, 32'h0000_0101);
    @(negedge clk);
    #1;
    check("b2b_empty", read_data_o, 32'h0000_0003);
    repeat (41) @(negedge clk);
    #1;
    check("b2b_idle", read_data_o, 32'h0000_0002);

    // Ten stores: 9 accepted, 10th overflows
    for (int i = 0; i < 10; i++) st(TXA, 32'hDEAD_BE00 | (32'h30 + 32'(i)));
    idle(STA);
    check("ovf_set", read_data_o, 32'h0000_080D);
    st(STA, 32'h0000_0008);
    idle(STA);
    check("ovf_clr", read_data_o, 32'h0000_0805);
    st(TXA, 32'h0000_0077);
    idle(STA);
    check("ovf_again", read_data_o, 32'h0000_080D);
    st(STA, 32'hFFFF_FFF7);
    idle(STA);
    check("ovf_keep", read_data_o, 32'h0000_080D);
    st(STA, 32'h0000_0008);
    idle(STA);
    check("ovf_clr2", read_data_o, 32'h0000_0805);
    repeat (380) @(negedge clk);
    #1;
    check("drain_idle", read_data_o, 32'h0000_0002);

    // Decode
    idle(STA);
    check("ld_st_hit", {31'b0, hit_o}, 32'd1);
    check("ld_st_rd",  read_data_o,    32'h0000_0002);
    idle(32'h0000_0108);
    check("ld_108_hit", {31'b0, hit_o}, 32'd0);
    check("ld_108_rd",  read_data_o,    32'd0);
    st(32'h0000_0108, 32'h0000_0055);
    st(32'h1000_0100, 32'h0000_0056);
    idle(STA);
    idle(STA);
    check("st_miss_status", read_data_o,     32'h0000_0002);
    check("st_miss_busy",   {31'b0, busy_o}, 32'd0);

    // Reset mid-DATA with three bytes queued
    st(TXA, 32'h0000_0011);
    st(TXA, 32'h0000_0012);
    st(TXA, 32'h0000_0013);
    st(TXA, 32'h0000_0014);
    idle(STA);
    check("pre_rst_q3", read_data_o, 32'h0000_0301);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_tx",     {31'b0, tx_o},   32'd1);
    check("mid_rst_busy",   {31'b0, busy_o}, 32'd0);
    check("mid_rst_status", read_data_o,     32'h0000_0002);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_line", {31'b0, tx_o}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data-memory store path.
- Consumes the core's data-memory outputs (MemWrite, DataAdr, WriteData) in parallel with data memory.
- Decodes two word addresses: stores to TX_ADDR queue a byte into a FIFO; a serializer shifts queued bytes out as 8N1 frames on tx_o.
- A status word is returned combinationally for load-path muxing.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal values ≥2.
- FIFO_DEPTH, 8: byte FIFO entries; must be a power of two, ≥2.
- TX_ADDR, 32'h0000_0100: byte-address of the transmit data register.
- STATUS_ADDR, 32'h0000_0104: byte-address of the status/control register.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_write_i  input  1  store strobe from core (MemWrite).
- data_adr_i  input  32  store/load address from core (DataAdr).
- write_data_i  input  32  store data from core (WriteData).
- hit_o  output  1  combinational: data_adr_i equals TX_ADDR or STATUS_ADDR.
- read_data_o  output  32  combinational status word; 0 when hit_o=0.
- tx_o  output  1  registered serial line, idle high.
- busy_o  output  1  registered: serializer not in IDLE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, applied on the clk edge.
- Reset values:
  - tx_o=1, busy_o=0.
  - FIFO empty; read and write pointers 0; count 0.
  - overflow flag 0; state IDLE; bit counter 0; baud counter 0.
- Address decode uses the full 32 bits, exact match only. Other addresses are ignored.
- Push: when mem_write_i=1 and data_adr_i=TX_ADDR, write_data_i[7:0] is written to the FIFO at the edge. Bits [31:8] are ignored.
- Full push: fullness is evaluated before the edge.
  - If the FIFO is full, the byte is dropped and sticky overflow is set to 1.
  - A pop in the same cycle does not rescue the push.
- Control write: mem_write_i=1, data_adr_i=STATUS_ADDR, write_data_i[3]=1 clears overflow. A simultaneous overflow event wins (overflow stays 1). Other bits are ignored.
- Status word read_data_o when data_adr_i=STATUS_ADDR:
  - [0] busy_o
  - [1] FIFO empty
  - [2] FIFO full
  - [3] overflow
  - [15:8] FIFO count (zero-extended)
  - All other bits 0.
  - Reads of TX_ADDR return 0.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If FIFO non-empty (pre-edge), pop the head into the shift register, set the baud counter to 0, and go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles; shift right at the end of each bit. After bit index 7 completes, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - if FIFO non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- busy_o=1 in START, DATA and STOP.
- Latency: a push at edge N makes count=1 after N. Edge N+1 pops and enters START, so tx_o falls after edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- Simultaneous push and pop on a non-full FIFO: both occur, count unchanged.
- Pop on empty cannot occur (gated).
- Reset mid-frame: the frame is aborted, tx_o=1 after the reset edge, and all queued bytes are discarded.

Test Plan:
- CLKS_PER_BIT=4, FIFO_DEPTH=8. Reset, then store 0x0000_00A5 to 0x100 -> tx_o low 4 cycles starting after the next edge; bits 1,0,1,0,0,1,0,1, 4 cycles each; stop high 4 cycles; busy_o high exactly 40 cycles; then IDLE.
- Store 0x41, 0x42, 0x43 back-to-back -> three contiguous 40-cycle frames, no idle gap; status count reads 2 during frame 1 after the first pop; empty=1 after the third pop.
- Store 10 bytes in 10 consecutive cycles while idle -> first pops at edge 2; 9 accepted (8 + the slot freed by the first pop, pushes after it); 10th dropped; overflow=1; status reads full=1 and overflow=1. Then store 0x8 to 0x104 -> overflow=0.
- Load from 0x104 with idle empty FIFO -> read_data_o=32'h0000_0002, hit_o=1. Load from 0x108 -> hit_o=0, read_data_o=0. Store to 0x108 -> no FIFO change.
- Assert reset mid-DATA of a frame with 3 bytes queued -> after the reset edge: tx_o=1, busy_o=0, status=0x0000_0002; no further frames emitted.
- Store to 0x104 with bit3=1 in the same cycle as a push to a full FIFO -> overflow remains 1.
